// File: rtl/portrait_ctrl.sv
// Portrait sequencer: slides a portrait in, holds it for N frame ticks, slides it out.
// ack/done are same-cycle pulses; req is ignored (not queued) while a sequence is active.
module portrait_ctrl #(
   parameter int SCREEN_H   = 480,
   parameter int PORTRAIT_H = 160,
   parameter int STEP       = 8
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic       req,
   input  logic [1:0] req_id,
   input  logic [7:0] hold_frames,
   input  logic       cancel,
   output logic       ack,
   output logic       done,
   output logic       busy,
   output logic       portrait_en,
   output logic [1:0] portrait_sel,
   output logic [9:0] y_start
);
   localparam logic [9:0] Y_OFF      = 10'(SCREEN_H);
   localparam logic [9:0] Y_ON       = 10'(SCREEN_H - PORTRAIT_H);
   localparam logic [9:0] Y_STEP     = 10'(STEP);
   // Last positions from which a single step lands on (or past) the end stop.
   localparam logic [9:0] Y_IN_LAST  = 10'(SCREEN_H - PORTRAIT_H + STEP);
   localparam logic [9:0] Y_OUT_LAST = 10'(SCREEN_H - STEP);

   typedef enum logic [1:0] {IDLE, SLIDE_IN, HOLD, SLIDE_OUT} state_t;

   state_t     state, state_nxt;
   logic       frame_clk_q;
   logic       tick;
   logic [7:0] hold_cnt, hold_cnt_nxt;
   logic [1:0] sel_nxt;
   logic [9:0] y_nxt;

   assign tick        = frame_clk & ~frame_clk_q;
   assign busy        = (state != IDLE);
   assign portrait_en = busy;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state        <= IDLE;
         frame_clk_q  <= 1'b0;
         hold_cnt     <= 8'd0;
         portrait_sel <= 2'd0;
         y_start      <= Y_OFF;
      end else begin
         state        <= state_nxt;
         frame_clk_q  <= frame_clk;
         hold_cnt     <= hold_cnt_nxt;
         portrait_sel <= sel_nxt;
         y_start      <= y_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      hold_cnt_nxt = hold_cnt;
      sel_nxt      = portrait_sel;
      y_nxt        = y_start;
      ack          = 1'b0;
      done         = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               ack          = 1'b1;
               sel_nxt      = req_id;
               hold_cnt_nxt = (hold_frames == 8'd0) ? 8'd1 : hold_frames;
               state_nxt    = SLIDE_IN;
            end
         end
         SLIDE_IN: begin
            // cancel wins over a coincident tick: retreat from where we are
            if (cancel) begin
               state_nxt = SLIDE_OUT;
            end else if (tick) begin
               if (y_start <= Y_IN_LAST) begin
                  y_nxt     = Y_ON;
                  state_nxt = HOLD;
               end else begin
                  y_nxt = y_start - Y_STEP;
               end
            end
         end
         HOLD: begin
            if (cancel) begin
               state_nxt = SLIDE_OUT;
            end else if (tick) begin
               if (hold_cnt <= 8'd1) begin
                  hold_cnt_nxt = 8'd0;
                  state_nxt    = SLIDE_OUT;
               end else begin
                  hold_cnt_nxt = hold_cnt - 8'd1;
               end
            end
         end
         SLIDE_OUT: begin
            if (tick) begin
               if (y_start >= Y_OUT_LAST) begin
                  y_nxt     = Y_OFF;
                  state_nxt = IDLE;
                  done      = 1'b1;
               end else begin
                  y_nxt = y_start + Y_STEP;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      // Pulses are combinational, so they must be masked while reset is held.
      if (Reset) begin
         ack  = 1'b0;
         done = 1'b0;
      end
   end
endmodule

// File: tb/tb_portrait_ctrl.sv
// Directed + randomized bench for portrait_ctrl against a tick-count model of the slide sequence.
module tb_portrait_ctrl;
   localparam int SH   = 480;
   localparam int PH   = 160;
   localparam int ST   = 8;
   localparam int N_IN = PH / ST;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       frame_clk;
   logic       req;
   logic [1:0] req_id;
   logic [7:0] hold_frames;
   logic       cancel;
   logic       ack;
   logic       done;
   logic       busy;
   logic       portrait_en;
   logic [1:0] portrait_sel;
   logic [9:0] y_start;

   int   checks = 0;
   int   errors = 0;
   int   ack_cnt = 0;
   int   done_cnt = 0;
   logic tick_done;
   logic frame_done;
   int   nticks;
   int   r_hh, r_gap, r_hi, r_ca;
   logic [1:0] r_id;
   logic [7:0] r_hf;

   portrait_ctrl #(.SCREEN_H(SH), .PORTRAIT_H(PH), .STEP(ST)) dut (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .req(req), .req_id(req_id),
      .hold_frames(hold_frames), .cancel(cancel), .ack(ack), .done(done), .busy(busy),
      .portrait_en(portrait_en), .portrait_sel(portrait_sel), .y_start(y_start)
   );

   always #5 Clk = ~Clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Expected top line after k ticks of an uncancelled sequence with effective hold hh.
   function automatic int model_y(input int k, input int hh);
      if (k <= N_IN) return SH - ST * k;
      if (k <= N_IN + hh) return SH - PH;
      return SH - PH + ST * (k - N_IN - hh);
   endfunction

   task automatic cyc(input logic fc, input logic cn, input logic rq);
      @(negedge Clk);
      frame_clk = fc;
      cancel    = cn;
      req       = rq;
      #1;
      if (ack === 1'b1) ack_cnt++;
      if (done === 1'b1) done_cnt++;
      tick_done = done;
   endtask

   // One frame period: frame_clk high for hi cycles, low for the rest of gap.
   task automatic frame(input int hi, input int gap, input logic cn, input logic rq);
      cyc(1'b1, cn, rq);
      frame_done = tick_done;
      for (int i = 1; i < gap; i++) cyc(i < hi, 1'b0, rq);
   endtask

   task automatic drain(output int n);
      n = 0;
      while (busy === 1'b1 && n < 400) begin
         frame(1, 2, 1'b0, 1'b0);
         n++;
      end
      chk("drain idle", 32'(busy), 0);
   endtask

   task automatic run_seq(input logic [1:0] id, input logic [7:0] hf, input int hi, input int gap,
                          input int cancel_at, input bit busy_req, input string tag);
      int hh, k_end, yc, ye, back;
      bit cut;
      hh    = (hf == 8'd0) ? 1 : int'(hf);
      cut   = (cancel_at >= 1) && (cancel_at <= N_IN + hh);
      yc    = cut ? model_y(cancel_at - 1, hh) : 0;
      back  = (SH - yc) / ST;
      k_end = cut ? cancel_at + ((back > 1) ? back : 1) : 2 * N_IN + hh;
      ack_cnt  = 0;
      done_cnt = 0;
      req_id      = id;
      hold_frames = hf;
      cyc(1'b0, 1'b0, 1'b1);
      chk({tag, " ack"}, 32'(ack), 1);
      chk({tag, " y at accept"}, 32'(y_start), SH);
      cyc(1'b0, 1'b0, 1'b0);
      chk({tag, " sel"}, 32'(portrait_sel), 32'(id));
      chk({tag, " busy/en"}, 32'({busy, portrait_en}), 3);
      for (int k = 1; k < k_end; k++) begin
         if (busy_req && k == N_IN + 1) req_id = 2'd1;
         frame(hi, gap, k == cancel_at, busy_req && (k > N_IN));
         ye = (cut && k >= cancel_at) ? yc + ST * (k - cancel_at) : model_y(k, hh);
         chk({tag, " y"}, 32'(y_start), 32'(ye));
         chk({tag, " busy mid"}, 32'(busy), 1);
         chk({tag, " no early done"}, 32'(frame_done), 0);
      end
      chk({tag, " single ack"}, 32'(ack_cnt), 1);
      chk({tag, " sel held"}, 32'(portrait_sel), 32'(id));
      cyc(1'b1, cancel_at == k_end, busy_req);
      chk({tag, " done on last tick"}, 32'(tick_done), 1);
      cyc(1'b0, 1'b0, busy_req);
      chk({tag, " idle"}, 32'(busy), 0);
      chk({tag, " ack after done"}, 32'(ack), 32'(busy_req));
      chk({tag, " y home"}, 32'(y_start), SH);
      chk({tag, " done once"}, 32'(done_cnt), 1);
      cyc(1'b0, 1'b0, 1'b0);
      chk({tag, " sel after"}, 32'(portrait_sel), busy_req ? 1 : 32'(id));
      chk({tag, " busy after"}, 32'(busy), 32'(busy_req));
   endtask

   initial begin
      Reset = 1'b1; frame_clk = 1'b0; req = 1'b0; cancel = 1'b0;
      req_id = 2'd0; hold_frames = 8'd0;
      #2;
      chk("reset y", 32'(y_start), SH);
      chk("reset busy/en", 32'({busy, portrait_en}), 0);
      chk("reset ack/done", 32'({ack, done}), 0);
      chk("reset sel", 32'(portrait_sel), 0);
      #20;
      @(negedge Clk);
      Reset = 1'b0;

      run_seq(2'd2, 8'd3, 8, 16, 0, 1'b0, "basic");
      run_seq(2'd1, 8'd0, 1, 4, 0, 1'b0, "zero_hold");
      run_seq(2'd3, 8'd2, 2, 5, 11, 1'b0, "cancel_in");
      run_seq(2'd0, 8'd4, 1, 3, N_IN + 2, 1'b0, "cancel_hold");
      run_seq(2'd2, 8'd1, 1, 2, N_IN + 6, 1'b0, "cancel_out_ignored");
      run_seq(2'd2, 8'd3, 3, 6, 0, 1'b1, "busy_req");
      drain(nticks);
      chk("busy_req second seq ticks", 32'(nticks), 2 * N_IN + 3);

      // Reset in HOLD: immediate, no clock edge, no done.
      req_id = 2'd1; hold_frames = 8'd5;
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0);
      for (int k = 1; k <= N_IN + 2; k++) frame(1, 2, 1'b0, 1'b0);
      chk("pre-reset hold y", 32'(y_start), SH - PH);
      done_cnt = 0;
      #2 Reset = 1'b1;
      #1;
      chk("async reset y", 32'(y_start), SH);
      chk("async reset busy/en", 32'({busy, portrait_en}), 0);
      chk("async reset sel", 32'(portrait_sel), 0);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      chk("no done through reset", 32'(done_cnt), 0);
      @(negedge Clk);
      Reset = 1'b0;
      run_seq(2'd1, 8'd2, 1, 3, 0, 1'b0, "post_reset");

      // frame_clk stuck high produces a single tick.
      req_id = 2'd3; hold_frames = 8'd2;
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 100; i++) cyc(1'b1, 1'b0, 1'b0);
      chk("level frame_clk one step", 32'(y_start), SH - ST);
      cyc(1'b0, 1'b0, 1'b0);
      drain(nticks);
      chk("level frame_clk remaining ticks", 32'(nticks), 2 * N_IN + 2 - 1);

      for (int r = 0; r < 8; r++) begin
         r_id  = 2'($urandom_range(0, 3));
         r_hf  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 5));
         r_hh  = (r_hf == 8'd0) ? 1 : int'(r_hf);
         r_gap = int'($urandom_range(2, 6));
         r_hi  = int'($urandom_range(1, r_gap - 1));
         r_ca  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 2 * N_IN + r_hh)) : 0;
         run_seq(r_id, r_hf, r_hi, r_gap, r_ca, 1'b0, "random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
